// File: rtl/ds_defs.sv
// Shared delta-sigma datapath constants used by the decimator and downstream PCM stages.
package ds_defs;

    localparam int unsigned DEF_DEC_RATIO = 64;
    localparam int unsigned DEF_LOG2_R    = 6;

    // A sinc^3 output spans 0..R^3, which needs 3*log2(R)+1 bits.
    function automatic int unsigned calc_out_w(input int unsigned log2_r);
        return 3 * log2_r + 1;
    endfunction

    localparam int unsigned PCM_W = calc_out_w(DEF_LOG2_R);

endpackage

// File: rtl/cic_comb_stage.sv
// One CIC comb section: a delay register plus a subtractor, advanced by an enable.
module cic_comb_stage
    import ds_defs::*;
#(
    parameter int unsigned W = PCM_W
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_en,
    input  logic [W-1:0] i_din,
    output logic [W-1:0] o_diff_c
);

    logic [W-1:0] r_d;

    // Difference against the previous decimated input; wraps modulo 2^W.
    assign o_diff_c = i_din - r_d;

    // Capture the current input as the delay for the next decimated sample.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_d <= '0;
        end else if (i_en) begin
            r_d <= i_din;
        end
    end

endmodule

// File: rtl/sinc3_decimator.sv
// Third-order CIC decimator: 1-bit delta-sigma stream in, unsigned PCM out at 1/R rate.
module sinc3_decimator
    import ds_defs::*;
#(
    parameter int unsigned DEC_RATIO = DEF_DEC_RATIO,
    parameter int unsigned LOG2_R    = DEF_LOG2_R,
    parameter int unsigned OUT_W     = calc_out_w(LOG2_R)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             bit_in,
    input  logic             bit_valid,
    output logic [OUT_W-1:0] dout,
    output logic             dout_valid
);

    logic [OUT_W-1:0]  r_i1;
    logic [OUT_W-1:0]  r_i2;
    logic [OUT_W-1:0]  r_i3;
    logic [LOG2_R-1:0] r_cnt;
    logic              r_tick;
    logic [OUT_W-1:0]  r_dout;
    logic              r_dout_valid;

    logic [OUT_W-1:0]  w_i1_next;
    logic [OUT_W-1:0]  w_i2_next;
    logic [OUT_W-1:0]  w_i3_next;
    logic              w_tick;
    logic [OUT_W-1:0]  w_c1;
    logic [OUT_W-1:0]  w_c2;
    logic [OUT_W-1:0]  w_c3;

    // Direct-form integrator cascade: each stage adds the freshly updated previous stage.
    assign w_i1_next = r_i1 + OUT_W'(bit_in);
    assign w_i2_next = r_i2 + w_i1_next;
    assign w_i3_next = r_i3 + w_i2_next;

    // The R-th accepted bit of a window closes it.
    assign w_tick = bit_valid && (r_cnt == LOG2_R'(DEC_RATIO - 1));

    // Integrators and window counter advance only on qualified bits; overflow wraps by design.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_i1   <= '0;
            r_i2   <= '0;
            r_i3   <= '0;
            r_cnt  <= '0;
            r_tick <= 1'b0;
        end else begin
            r_tick <= w_tick;
            if (bit_valid) begin
                r_i1  <= w_i1_next;
                r_i2  <= w_i2_next;
                r_i3  <= w_i3_next;
                r_cnt <= r_cnt + LOG2_R'(1);
            end
        end
    end

    // Comb chain runs once per window on the registered i3, concurrent with the next window.
    cic_comb_stage #(.W(OUT_W)) u_comb1 (
        .i_clk    (clk),
        .i_rst    (rst),
        .i_en     (r_tick),
        .i_din    (r_i3),
        .o_diff_c (w_c1)
    );

    cic_comb_stage #(.W(OUT_W)) u_comb2 (
        .i_clk    (clk),
        .i_rst    (rst),
        .i_en     (r_tick),
        .i_din    (w_c1),
        .o_diff_c (w_c2)
    );

    cic_comb_stage #(.W(OUT_W)) u_comb3 (
        .i_clk    (clk),
        .i_rst    (rst),
        .i_en     (r_tick),
        .i_din    (w_c2),
        .o_diff_c (w_c3)
    );

    // Register the PCM sample and its one-cycle strobe; dout holds between strobes.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_dout       <= '0;
            r_dout_valid <= 1'b0;
        end else begin
            r_dout_valid <= r_tick;
            if (r_tick) begin
                r_dout <= w_c3;
            end
        end
    end

    assign dout       = r_dout;
    assign dout_valid = r_dout_valid;

endmodule

// File: tb/tb_sinc3_decimator.sv
// Bench for sinc3_decimator: sinc^3 impulse-response convolution model vs. DUT.
module tb_sinc3_decimator;

    localparam int unsigned R  = 64;
    localparam int unsigned L2 = 6;
    localparam int unsigned W  = 19;
    localparam int unsigned HL = 3 * R - 2;

    logic         clk = 1'b0;
    logic         rst;
    logic         bit_in;
    logic         bit_valid;
    logic [W-1:0] dout;
    logic         dout_valid;

    always #5 clk = ~clk;

    sinc3_decimator #(.DEC_RATIO(R), .LOG2_R(L2), .OUT_W(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .bit_in     (bit_in),
        .bit_valid  (bit_valid),
        .dout       (dout),
        .dout_valid (dout_valid)
    );

    // Model state: impulse response of (1+z^-1+..+z^-(R-1))^3 and accepted-bit history.
    int unsigned h [HL];
    bit          xq[$];
    int unsigned acc_n;
    logic        pend_valid;
    int unsigned pend_dout;
    logic        exp_valid;
    int unsigned exp_dout;
    logic        obs_valid;
    int unsigned obs_dout;
    int          checks;
    int          errors;
    int unsigned ones_ref [3] = '{45760, 220480, 262144};

    function automatic void build_h();
        int unsigned b2 [2*R-1];
        for (int i = 0; i < 2*int'(R)-1; i++) b2[i] = 0;
        for (int i = 0; i < HL; i++) h[i] = 0;
        for (int i = 0; i < int'(R); i++)
            for (int j = 0; j < int'(R); j++) b2[i+j] += 1;
        for (int i = 0; i < 2*int'(R)-1; i++)
            for (int j = 0; j < int'(R); j++) h[i+j] += b2[i];
    endfunction

    // Filter output at the current accepted sample, zero history before reset.
    function automatic int unsigned model_out();
        int unsigned s = 0;
        int n = xq.size();
        for (int j = 0; j < int'(HL); j++)
            if (j < n && xq[n-1-j]) s += h[j];
        return s;
    endfunction

    function automatic void model_clear();
        xq.delete();
        acc_n      = 0;
        pend_valid = 1'b0;
        pend_dout  = 0;
        exp_valid  = 1'b0;
        exp_dout   = 0;
    endfunction

    // Drive one cycle, sample outputs after the edge, then advance the model.
    task automatic step(input logic b, input logic v);
        bit_in    = b;
        bit_valid = v;
        @(posedge clk);
        #1;
        obs_valid = dout_valid;
        obs_dout  = int'(dout);
        exp_valid = pend_valid;
        if (pend_valid) exp_dout = pend_dout;
        pend_valid = 1'b0;
        if (v) begin
            xq.push_back(b);
            if (xq.size() > HL) void'(xq.pop_front());
            acc_n++;
            if (acc_n % R == 0) begin
                pend_valid = 1'b1;
                pend_dout  = model_out();
            end
        end
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        bit_in    = 1'b0;
        bit_valid = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_clear();
        obs_valid = dout_valid;
        obs_dout  = int'(dout);
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (obs_valid !== 1'b0) begin
            errors++; $display("FAIL reset_valid: got %0b want 0", obs_valid);
        end
        checks++;
        if (obs_dout !== 0) begin
            errors++; $display("FAIL reset_dout: got %0d want 0", obs_dout);
        end
        step(1'b1, 1'b0);
        checks++;
        if (obs_valid !== 1'b0 || obs_dout !== 0) begin
            errors++; $display("FAIL reset_hold: got v=%0b d=%0d want v=0 d=0", obs_valid, obs_dout);
        end
    endtask

    task automatic test_const_ones();
        int pulses = 0;
        do_reset();
        for (int c = 0; c < 10 * int'(R) + 2; c++) begin
            step(1'b1, 1'b1);
            checks++;
            if (obs_valid !== exp_valid || obs_dout !== exp_dout) begin
                errors++;
                $display("FAIL ones_cyc%0d: got v=%0b d=%0d want v=%0b d=%0d",
                         c, obs_valid, obs_dout, exp_valid, exp_dout);
            end
            if (obs_valid === 1'b1) begin
                checks++;
                if (obs_dout !== ones_ref[(pulses < 3) ? pulses : 2]) begin
                    errors++;
                    $display("FAIL ones_pulse%0d: got %0d want %0d",
                             pulses, obs_dout, ones_ref[(pulses < 3) ? pulses : 2]);
                end
                pulses++;
            end
        end
        checks++;
        if (pulses != 10) begin
            errors++; $display("FAIL ones_count: got %0d want 10", pulses);
        end
    endtask

    task automatic test_zeros();
        int pulses = 0;
        do_reset();
        for (int c = 0; c < 4 * int'(R) + 2; c++) begin
            step(1'b0, 1'b1);
            checks++;
            if (obs_valid !== exp_valid || obs_dout !== 0) begin
                errors++;
                $display("FAIL zeros_cyc%0d: got v=%0b d=%0d want v=%0b d=0",
                         c, obs_valid, obs_dout, exp_valid);
            end
            if (obs_valid === 1'b1) pulses++;
        end
        checks++;
        if (pulses != 4) begin
            errors++; $display("FAIL zeros_count: got %0d want 4", pulses);
        end
    endtask

    task automatic test_alternating();
        int pulses = 0;
        do_reset();
        for (int c = 0; c < 6 * int'(R) + 2; c++) begin
            step(c[0] ? 1'b0 : 1'b1, 1'b1);
            checks++;
            if (obs_valid !== exp_valid || obs_dout !== exp_dout) begin
                errors++;
                $display("FAIL alt_cyc%0d: got v=%0b d=%0d want v=%0b d=%0d",
                         c, obs_valid, obs_dout, exp_valid, exp_dout);
            end
            if (obs_valid === 1'b1) begin
                if (pulses >= 2) begin
                    checks++;
                    if (obs_dout !== 131072) begin
                        errors++; $display("FAIL alt_pulse%0d: got %0d want 131072", pulses, obs_dout);
                    end
                end
                pulses++;
            end
        end
    endtask

    task automatic test_gaps();
        int pulses = 0;
        int cyc = 0;
        do_reset();
        while (pulses < 5 && cyc < 4000) begin
            step(1'b1, 1'($urandom_range(0, 1)));
            checks++;
            if (obs_valid !== exp_valid || obs_dout !== exp_dout) begin
                errors++;
                $display("FAIL gaps_cyc%0d: got v=%0b d=%0d want v=%0b d=%0d",
                         cyc, obs_valid, obs_dout, exp_valid, exp_dout);
            end
            if (obs_valid === 1'b1) begin
                checks++;
                if (obs_dout !== ones_ref[(pulses < 3) ? pulses : 2]) begin
                    errors++;
                    $display("FAIL gaps_pulse%0d: got %0d want %0d",
                             pulses, obs_dout, ones_ref[(pulses < 3) ? pulses : 2]);
                end
                pulses++;
            end
            cyc++;
        end
        checks++;
        if (pulses != 5) begin
            errors++; $display("FAIL gaps_timeout: got %0d pulses want 5", pulses);
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 12 * int'(R); c++) begin
            step(1'($urandom_range(0, 1)), ($urandom_range(0, 3) != 0));
            checks++;
            if (obs_valid !== exp_valid || obs_dout !== exp_dout) begin
                errors++;
                $display("FAIL rand_cyc%0d: got v=%0b d=%0d want v=%0b d=%0d",
                         c, obs_valid, obs_dout, exp_valid, exp_dout);
            end
        end
    endtask

    task automatic test_reset_mid();
        int pulses = 0;
        int cyc = 0;
        do_reset();
        // Two full windows, then 30 more bits so dout is nonzero mid-window.
        for (int c = 0; c < 2 * int'(R) + 30; c++) step(1'b1, 1'b1);
        checks++;
        if (obs_dout !== 220480) begin
            errors++; $display("FAIL mid_pre: got %0d want 220480", obs_dout);
        end
        rst       = 1'b1;
        bit_in    = 1'b1;
        bit_valid = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_clear();
        checks++;
        if (dout_valid !== 1'b0 || dout !== '0) begin
            errors++; $display("FAIL mid_clear: got v=%0b d=%0d want v=0 d=0", dout_valid, dout);
        end
        while (pulses < 1 && cyc < 200) begin
            step(1'b1, 1'b1);
            checks++;
            if (obs_valid !== exp_valid || obs_dout !== exp_dout) begin
                errors++;
                $display("FAIL mid_cyc%0d: got v=%0b d=%0d want v=%0b d=%0d",
                         cyc, obs_valid, obs_dout, exp_valid, exp_dout);
            end
            if (obs_valid === 1'b1) begin
                checks++;
                if (obs_dout !== 45760 || cyc != int'(R)) begin
                    errors++;
                    $display("FAIL mid_first: got d=%0d at cyc %0d want d=45760 at cyc %0d",
                             obs_dout, cyc, R);
                end
                pulses++;
            end
            cyc++;
        end
        checks++;
        if (pulses != 1) begin
            errors++; $display("FAIL mid_timeout: got %0d pulses want 1", pulses);
        end
        // Reset while the comb cycle is pending must suppress the pulse.
        do_reset();
        for (int c = 0; c < int'(R); c++) step(1'b1, 1'b1);
        rst       = 1'b1;
        bit_valid = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_clear();
        checks++;
        if (dout_valid !== 1'b0 || dout !== '0) begin
            errors++; $display("FAIL comb_rst: got v=%0b d=%0d want v=0 d=0", dout_valid, dout);
        end
        step(1'b0, 1'b0);
        checks++;
        if (obs_valid !== 1'b0) begin
            errors++; $display("FAIL comb_rst_after: got v=%0b want 0", obs_valid);
        end
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        rst       = 1'b1;
        bit_in    = 1'b0;
        bit_valid = 1'b0;
        build_h();
        model_clear();
        repeat (2) @(posedge clk);
        test_reset();
        test_const_ones();
        test_zeros();
        test_alternating();
        test_gaps();
        test_random();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
